od_input_filter: RTL and testbench

//  Conditions the raw input from an open-drain pad (the DIN0 of an SB_IO_OD

---
 rtl/od_input_filter.sv | 68 ++++++
 tb/tb_od_input_filter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/od_input_filter.sv
// od_input_filter: synchronizes, glitch-filters and edge-detects an open-drain pad input
module od_input_filter #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 16,
    parameter bit RESET_LEVEL   = 1'b1,
    parameter int GLITCH_W      = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pin_in,
    input  logic                glitch_clear,
    output logic                level_out,
    output logic                rise,
    output logic                fall,
    output logic [GLITCH_W-1:0] glitch_count
);
    localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   w_s_q;
    logic                   w_mismatch;
    logic                   w_accept;
    logic                   w_glitch;
    logic                   w_sat;

    assign w_s_q      = r_sync[SYNC_STAGES-1];
    assign w_mismatch = w_s_q != level_out;
    assign w_accept   = w_mismatch && (r_cnt == CNT_LAST);
    assign w_glitch   = !w_mismatch && (r_cnt != '0);
    assign w_sat      = &glitch_count;

    // plain shift chain so the first flop sees the raw pad with nothing in front of it
    always_ff @(posedge clk)
        r_sync <= reset ? {SYNC_STAGES{RESET_LEVEL}} : {r_sync[SYNC_STAGES-2:0], pin_in};

    // count consecutive mismatching cycles; accept on the last one, drop back to idle on a match
    always_ff @(posedge clk) begin
        if (reset) begin
            level_out <= RESET_LEVEL;
            r_cnt     <= '0;
            rise      <= 1'b0;
            fall      <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (w_accept) begin
                level_out <= w_s_q;
                r_cnt     <= '0;
                rise      <= w_s_q;
                fall      <= ~w_s_q;
            end else if (w_mismatch) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    // saturating rejected-glitch counter; clear wins over a same-cycle increment
    always_ff @(posedge clk) begin
        if (reset || glitch_clear)
            glitch_count <= '0;
        else if (w_glitch && !w_sat)
            glitch_count <= glitch_count + 1'b1;
    end
endmodule

// File: tb/tb_od_input_filter.sv
// tb_od_input_filter: directed scoreboard bench for od_input_filter (default and fast-filter instances)
module tb_od_input_filter;
    typedef struct {
        int   ec;
        logic r;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pin0 = 1'b0;
    logic       pin1 = 1'b1;
    logic       gclr = 1'b0;
    logic       level0, rise0, fall0, level1, rise1, fall1;
    logic [7:0] gc0, gc1;
    int         ec = 0;
    int         checks = 0;
    int         failures = 0;
    ev_t        q0[$];
    ev_t        q1[$];

    od_input_filter dut0 (
        .clk(clk), .reset(reset), .pin_in(pin0), .glitch_clear(gclr),
        .level_out(level0), .rise(rise0), .fall(fall0), .glitch_count(gc0)
    );

    od_input_filter #(.SYNC_STAGES(3), .FILTER_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .pin_in(pin1), .glitch_clear(gclr),
        .level_out(level1), .rise(rise1), .fall(fall1), .glitch_count(gc1)
    );

    always #5 clk = ~clk;

    // edge counter: after posedge k, ec == k
    always @(posedge clk) ec <= ec + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push0(input int at, input logic r);
        ev_t e;
        e.ec = at;
        e.r  = r;
        q0.push_back(e);
    endtask

    task automatic push1(input int at, input logic r);
        ev_t e;
        e.ec = at;
        e.r  = r;
        q1.push_back(e);
    endtask

    // advance one cycle and reconcile any strobes against the scoreboards
    task automatic step();
        ev_t e;
        @(negedge clk);
        if (rise0 && fall0) chk("dut0 both strobes", {rise0, fall0}, 2'b00);
        if (rise1 && fall1) chk("dut1 both strobes", {rise1, fall1}, 2'b00);
        if (rise0 || fall0) begin
            if (q0.size() == 0) chk("dut0 unexpected strobe", {rise0, fall0}, 2'b00);
            else begin
                e = q0.pop_front();
                chk("dut0 strobe edge", ec, e.ec);
                chk("dut0 strobe kind", {rise0, fall0}, {e.r, ~e.r});
            end
        end else if (q0.size() > 0 && q0[0].ec <= ec) begin
            e = q0.pop_front();
            chk("dut0 missed strobe", {rise0, fall0}, {e.r, ~e.r});
        end
        if (rise1 || fall1) begin
            if (q1.size() == 0) chk("dut1 unexpected strobe", {rise1, fall1}, 2'b00);
            else begin
                e = q1.pop_front();
                chk("dut1 strobe edge", ec, e.ec);
                chk("dut1 strobe kind", {rise1, fall1}, {e.r, ~e.r});
            end
        end else if (q1.size() > 0 && q1[0].ec <= ec) begin
            e = q1.pop_front();
            chk("dut1 missed strobe", {rise1, fall1}, {e.r, ~e.r});
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // two-cycle low excursion on dut0, ending after the glitch edge
    task automatic glitch0();
        pin0 = 1'b0;
        steps(2);
        pin0 = 1'b1;
        steps(3);
    endtask

    initial begin
        // 1: reset with pin low, then release
        steps(3);
        chk("reset level", level0, 1'b1);
        chk("reset rise", rise0, 1'b0);
        chk("reset fall", fall0, 1'b0);
        chk("reset gc", gc0, 8'd0);
        chk("dut1 reset level", level1, 1'b1);
        reset = 1'b0;
        push0(ec + 18, 1'b0);
        steps(17);
        chk("level before accept", level0, 1'b1);
        step();
        chk("level after accept", level0, 1'b0);
        steps(6);
        chk("gc after first fall", gc0, 8'd0);

        // 2: back to high, then 10/15/16-cycle low pulses
        pin0 = 1'b1;
        push0(ec + 18, 1'b1);
        steps(25);
        chk("level high again", level0, 1'b1);
        pin0 = 1'b0;
        steps(10);
        pin0 = 1'b1;
        steps(20);
        chk("10-cycle pulse level", level0, 1'b1);
        chk("10-cycle pulse gc", gc0, 8'd1);
        pin0 = 1'b0;
        steps(15);
        pin0 = 1'b1;
        steps(20);
        chk("15-cycle pulse level", level0, 1'b1);
        chk("15-cycle pulse gc", gc0, 8'd2);
        pin0 = 1'b0;
        push0(ec + 18, 1'b0);
        push0(ec + 34, 1'b1);
        steps(16);
        pin0 = 1'b1;
        steps(40);
        chk("16-cycle pulse level", level0, 1'b1);
        chk("16-cycle pulse gc", gc0, 8'd2);

        // 3: go low, then rise with a 3-cycle dip right after acceptance
        pin0 = 1'b0;
        push0(ec + 18, 1'b0);
        steps(25);
        pin0 = 1'b1;
        push0(ec + 18, 1'b1);
        steps(20);
        pin0 = 1'b0;
        steps(3);
        pin0 = 1'b1;
        steps(25);
        chk("dip level", level0, 1'b1);
        chk("dip gc", gc0, 8'd3);

        // 4: saturation and clear priority
        for (int i = 0; i < 252; i++) glitch0();
        chk("gc at 255", gc0, 8'd255);
        glitch0();
        chk("gc saturated", gc0, 8'd255);
        pin0 = 1'b0;
        steps(2);
        pin0 = 1'b1;
        steps(2);
        gclr = 1'b1;
        step();
        gclr = 1'b0;
        chk("clear beats glitch", gc0, 8'd0);
        step();
        glitch0();
        chk("gc after clear", gc0, 8'd1);
        chk("level after glitches", level0, 1'b1);

        // 5: reset while cnt == 12
        pin0 = 1'b0;
        steps(14);
        reset = 1'b1;
        steps(3);
        chk("midfilter reset level", level0, 1'b1);
        chk("midfilter reset gc", gc0, 8'd0);
        reset = 1'b0;
        push0(ec + 18, 1'b0);
        steps(17);
        chk("post-reset full latency", level0, 1'b1);
        steps(8);
        chk("post-reset level", level0, 1'b0);

        // 6: fast instance, SYNC_STAGES=3, FILTER_CYCLES=1
        pin1 = 1'b0;
        push1(ec + 4, 1'b0);
        steps(3);
        chk("dut1 level before", level1, 1'b1);
        step();
        chk("dut1 level after fall", level1, 1'b0);
        steps(4);
        pin1 = 1'b1;
        push1(ec + 4, 1'b1);
        steps(6);
        chk("dut1 level after rise", level1, 1'b1);
        pin1 = 1'b0;
        push1(ec + 4, 1'b0);
        push1(ec + 5, 1'b1);
        step();
        pin1 = 1'b1;
        steps(8);
        chk("dut1 level after pulse", level1, 1'b1);
        chk("dut1 gc", gc1, 8'd0);

        chk("dut0 pending strobes", q0.size(), 0);
        chk("dut1 pending strobes", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
